// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port 128x32 memory.
// Each access runs IDLE -> ISSUE -> RESP. All memory-side outputs come straight from flops.
module mem_port_arbiter #(
  parameter int AW         = 7,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state_reg, state_next;
  logic          gnt_reg, gnt_next;
  logic          we_hold_reg, we_hold_next;
  logic [AW-1:0] addr_hold_reg, addr_hold_next;
  logic [DW-1:0] wdata_hold_reg, wdata_hold_next;
  logic          mem_cs_reg, mem_cs_next;
  logic          mem_we_reg, mem_we_next;
  logic          ack0_reg, ack0_next;
  logic          ack1_reg, ack1_next;
  logic          busy_reg, busy_next;
  logic [DW-1:0] rdata0_reg, rdata0_next;
  logic [DW-1:0] rdata1_reg, rdata1_next;
  logic          winner;

  // Port 1 wins when alone, or on a round-robin tie when port 0 was served last.
  assign winner = p1_req && (!p0_req || ((FIXED_PRIO == 0) && !gnt_reg));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      gnt_reg        <= 1'b1;
      we_hold_reg    <= 1'b0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      mem_cs_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      we_hold_reg    <= we_hold_next;
      addr_hold_reg  <= addr_hold_next;
      wdata_hold_reg <= wdata_hold_next;
      mem_cs_reg     <= mem_cs_next;
      mem_we_reg     <= mem_we_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      busy_reg       <= busy_next;
      rdata0_reg     <= rdata0_next;
      rdata1_reg     <= rdata1_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    we_hold_next    = we_hold_reg;
    addr_hold_next  = addr_hold_reg;
    wdata_hold_next = wdata_hold_reg;
    mem_cs_next     = 1'b0;
    mem_we_next     = 1'b0;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    busy_next       = 1'b0;
    rdata0_next     = rdata0_reg;
    rdata1_next     = rdata1_reg;
    case (state_reg)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt_next        = winner;
          we_hold_next    = winner ? p1_we : p0_we;
          addr_hold_next  = winner ? p1_addr : p0_addr;
          wdata_hold_next = winner ? p1_wdata : p0_wdata;
          mem_cs_next     = 1'b1;
          mem_we_next     = winner ? p1_we : p0_we;
          busy_next       = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        // The memory has produced read data on the falling edge inside this cycle.
        if (!we_hold_reg) begin
          if (gnt_reg) rdata1_next = mem_rdata;
          else         rdata0_next = mem_rdata;
        end
        ack0_next  = !gnt_reg;
        ack1_next  = gnt_reg;
        busy_next  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_cs    = mem_cs_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = addr_hold_reg;
  assign mem_wdata = wdata_hold_reg;
  assign p0_ack    = ack0_reg;
  assign p1_ack    = ack1_reg;
  assign p0_rdata  = rdata0_reg;
  assign p1_rdata  = rdata1_reg;
  assign busy      = busy_reg;
  assign gnt_id    = gnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance backed by a falling-edge memory
// model, plus a fixed-priority instance that shares the same request stimulus.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [6:0]  p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] zero_rdata = '0;

  logic        d0_p0_ack, d0_p1_ack, d0_mem_cs, d0_mem_we, d0_busy, d0_gnt;
  logic [31:0] d0_p0_rdata, d0_p1_rdata, d0_mem_wdata;
  logic [6:0]  d0_mem_addr;
  logic        d1_p0_ack, d1_p1_ack, d1_mem_cs, d1_mem_we, d1_busy, d1_gnt;
  logic [31:0] d1_p0_rdata, d1_p1_rdata, d1_mem_wdata;
  logic [6:0]  d1_mem_addr;

  logic [31:0] mem [128];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(7), .DW(32), .FIXED_PRIO(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(d0_p0_ack), .p0_rdata(d0_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(d0_p1_ack), .p1_rdata(d0_p1_rdata),
    .mem_cs(d0_mem_cs), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr),
    .mem_wdata(d0_mem_wdata), .mem_rdata(mem_rdata),
    .busy(d0_busy), .gnt_id(d0_gnt)
  );

  mem_port_arbiter #(.AW(7), .DW(32), .FIXED_PRIO(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(d1_p0_ack), .p0_rdata(d1_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(d1_p1_ack), .p1_rdata(d1_p1_rdata),
    .mem_cs(d1_mem_cs), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(zero_rdata),
    .busy(d1_busy), .gnt_id(d1_gnt)
  );

  // Single-port memory: acts on the falling edge, as the real part does.
  always @(negedge CLK) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (d0_mem_cs) begin
      if (d0_mem_we) mem[d0_mem_addr] <= d0_mem_wdata;
      else           mem_rdata <= mem[d0_mem_addr];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge CLK);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %s: observed %h expected %h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    preload(7'h05, 32'h2002000A);
    preload(7'h10, 32'h11111111);
    preload(7'h20, 32'h22222222);
    check("rst_cs",     {31'b0, d0_mem_cs}, 32'd0);
    check("rst_we",     {31'b0, d0_mem_we}, 32'd0);
    check("rst_busy",   {31'b0, d0_busy}, 32'd0);
    check("rst_acks",   {30'b0, d0_p0_ack, d0_p1_ack}, 32'd0);
    check("rst_gnt",    {31'b0, d0_gnt}, 32'd1);
    check("rst_addr",   {25'b0, d0_mem_addr}, 32'd0);
    check("rst_wdata",  d0_mem_wdata, 32'd0);
    check("rst_rdata0", d0_p0_rdata, 32'd0);
    check("rst_rdata1", d0_p1_rdata, 32'd0);
    tick();
    RST = 1'b1;

    // Test 1: p0 read of 0x05
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'h05;
    tick();
    check("t1_cs",   {31'b0, d0_mem_cs}, 32'd1);
    check("t1_addr", {25'b0, d0_mem_addr}, 32'h05);
    check("t1_we",   {31'b0, d0_mem_we}, 32'd0);
    check("t1_busy", {31'b0, d0_busy}, 32'd1);
    check("t1_noack", {31'b0, d0_p0_ack}, 32'd0);
    tick();
    check("t1_ack",   {31'b0, d0_p0_ack}, 32'd1);
    check("t1_rdata", d0_p0_rdata, 32'h2002000A);
    check("t1_cs_off", {31'b0, d0_mem_cs}, 32'd0);
    p0_req = 1'b0;
    tick();
    check("t1_ack_end", {31'b0, d0_p0_ack}, 32'd0);
    check("t1_hold",    d0_p0_rdata, 32'h2002000A);
    check("t1_idle",    {31'b0, d0_busy}, 32'd0);

    // Test 2: p1 write 0xDEADBEEF to 0x7F, then p0 reads it back
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 7'h7F; p1_wdata = 32'hDEADBEEF;
    tick();
    check("t2_we",    {31'b0, d0_mem_we}, 32'd1);
    check("t2_cs",    {31'b0, d0_mem_cs}, 32'd1);
    check("t2_addr",  {25'b0, d0_mem_addr}, 32'h7F);
    check("t2_wdata", d0_mem_wdata, 32'hDEADBEEF);
    check("t2_gnt",   {31'b0, d0_gnt}, 32'd1);
    tick();
    check("t2_acks",   {30'b0, d0_p0_ack, d0_p1_ack}, 32'd1);
    check("t2_we_off", {31'b0, d0_mem_we}, 32'd0);
    p1_req = 1'b0; p1_we = 1'b0;
    tick();
    p0_req = 1'b1; p0_addr = 7'h7F;
    tick();
    check("t2_rd_addr", {25'b0, d0_mem_addr}, 32'h7F);
    tick();
    check("t2_rd_ack",   {31'b0, d0_p0_ack}, 32'd1);
    check("t2_rd_rdata", d0_p0_rdata, 32'hDEADBEEF);
    p0_req = 1'b0;
    tick();

    // Test 5: address change during ISSUE is ignored
    p0_req = 1'b1; p0_addr = 7'h10;
    tick();
    p0_addr = 7'h20;
    #1;
    check("t5_addr",  {25'b0, d0_mem_addr}, 32'h10);
    tick();
    check("t5_ack",   {31'b0, d0_p0_ack}, 32'd1);
    check("t5_rdata", d0_p0_rdata, 32'h11111111);
    p0_req = 1'b0;
    tick();

    // Tests 3 and 4: fresh reset, both ports requesting continuously
    RST = 1'b0;
    #1;
    check("r2_rdata0", d0_p0_rdata, 32'd0);
    check("r2_gnt",    {31'b0, d0_gnt}, 32'd1);
    tick();
    RST = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'h05;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 7'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_gnt%0d", i), {31'b0, d0_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("t4_gnt%0d", i), {31'b0, d1_gnt}, 32'd0);
      check($sformatf("t3_cs%0d", i),  {31'b0, d0_mem_cs}, 32'd1);
      tick();
      check($sformatf("t3_acks%0d", i), {30'b0, d0_p0_ack, d0_p1_ack},
            (i % 2 == 0) ? 32'd2 : 32'd1);
      check($sformatf("t4_acks%0d", i), {30'b0, d1_p0_ack, d1_p1_ack}, 32'd2);
      if (i == 3) p0_req = 1'b0;
      tick();
      check($sformatf("t3_gap%0d", i), {30'b0, d0_p0_ack, d0_p1_ack}, 32'd0);
    end
    tick();
    check("t4_p1_gnt", {31'b0, d1_gnt}, 32'd1);
    tick();
    check("t4_p1_acks", {30'b0, d1_p0_ack, d1_p1_ack}, 32'd1);
    p1_req = 1'b0;
    tick();

    // Test 6: asynchronous reset in the middle of an ISSUE cycle
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 7'h05; p1_wdata = 32'hCAFEF00D;
    tick();
    check("t6_pre_cs", {31'b0, d0_mem_cs}, 32'd1);
    check("t6_pre_we", {31'b0, d0_mem_we}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("t6_cs",   {31'b0, d0_mem_cs}, 32'd0);
    check("t6_we",   {31'b0, d0_mem_we}, 32'd0);
    check("t6_busy", {31'b0, d0_busy}, 32'd0);
    check("t6_acks", {30'b0, d0_p0_ack, d0_p1_ack}, 32'd0);
    tick();
    check("t6_noack", {31'b0, d0_p1_ack}, 32'd0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    tick();
    check("t6_re_cs",  {31'b0, d0_mem_cs}, 32'd1);
    check("t6_re_gnt", {31'b0, d0_gnt}, 32'd1);
    tick();
    check("t6_re_ack", {30'b0, d0_p0_ack, d0_p1_ack}, 32'd1);
    p1_req = 1'b0; p1_we = 1'b0;
    tick();
    check("t6_end", {31'b0, d0_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
